// File: rtl/sipo_deser.sv
// Serial-in, parallel-out frame receiver: start(0), WIDTH data bits, stop(1).
// The completed word sits in a one-entry valid/ready buffer; framing errors and overruns pulse.
module sipo_deser #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             bit_en,
    input  logic             sin,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             busy
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [WIDTH-1:0] dout_nx;
    logic             valid_nx;
    logic             ferr_nx;
    logic             ovr_nx;

    // Shift direction chosen so the first-received bit ends at bit 0 (LSB first) or WIDTH-1.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] cur, input logic b);
        if (LSB_FIRST)
            return {b, cur[WIDTH-1:1]};
        else
            return {cur[WIDTH-2:0], b};
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            shreg      <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nx;
            cnt        <= cnt_nx;
            shreg      <= shreg_nx;
            dout       <= dout_nx;
            dout_valid <= valid_nx;
            frame_err  <= ferr_nx;
            overrun    <= ovr_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        shreg_nx = shreg;
        dout_nx  = dout;
        // A consumed word clears unless a new one loads below.
        valid_nx = dout_valid & ~dout_ready;
        ferr_nx  = 1'b0;
        ovr_nx   = 1'b0;

        if (bit_en) begin
            case (state)
                IDLE: begin
                    if (!sin) begin
                        cnt_nx   = '0;
                        state_nx = DATA;
                    end
                end
                DATA: begin
                    shreg_nx = shift_in(shreg, sin);
                    // Counter holds at its last value so it never wraps inside a frame.
                    if (cnt == LAST) begin
                        state_nx = STOP;
                    end else begin
                        cnt_nx = cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    state_nx = IDLE;
                    if (!sin) begin
                        ferr_nx = 1'b1;
                    end else if (dout_valid && !dout_ready) begin
                        ovr_nx = 1'b1;
                    end else begin
                        dout_nx  = shreg;
                        valid_nx = 1'b1;
                    end
                end
                default: begin
                    state_nx = IDLE;
                end
            endcase
        end
    end

    assign busy = (state == DATA) || (state == STOP);

endmodule
